// File: rtl/apb_timer_multi_if.sv
// APB slave bus bundle for apb_timer_multi.
// Carries the select/enable/write/address/data request signals and the
// registered read data plus one-cycle completion pulse back to the master.
interface apb_timer_multi_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_timer_multi.sv
// apb_timer_multi: NCH independent CWIDTH-bit down-counters behind an APB slave.
// Each channel has one-shot/periodic mode, interrupt enable and a sticky W1C
// pending flag; o_irq is pending & IE per channel, o_done is the OR of o_irq.
// Optional feature macro: APB_TIMER_MULTI_PRESCALE_EN adds a shared 16-bit
// prescaler at 0x104; without it every clock is a tick and 0x104 reads 0.
// Register map: channel n at 0x10*n (+0 CTRL, +4 LOAD, +8 COUNT, +C STATUS),
// 0x100 IRQSUM, 0x104 PRESCALE. Address bits [1:0] are ignored.
module apb_timer_multi #(
  parameter int NCH    = 4,
  parameter int CWIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  apb_timer_multi_if.slave   s_apb,
  output logic [NCH-1:0]     o_irq,
  output logic               o_done
);

  logic              r_pready;
  logic [31:0]       r_prdata;

  logic [NCH-1:0]    r_en;
  logic [NCH-1:0]    r_periodic;
  logic [NCH-1:0]    r_ie;
  logic [NCH-1:0]    r_pend;
  logic [CWIDTH-1:0] r_load  [NCH];
  logic [CWIDTH-1:0] r_count [NCH];

  logic              w_access;
  logic              w_wr;
  logic              w_rd;
  logic              w_chRegion;
  logic [3:0]        w_chIdx;
  logic [1:0]        w_regSel;
  logic              w_isIrqSum;
  logic              w_isPrescale;
  logic              w_tick;
  logic [31:0]       w_rdata;
  logic [NCH-1:0]    w_irq;
  logic [NCH-1:0]    w_wrCtrl;
  logic [NCH-1:0]    w_wrLoad;
  logic [NCH-1:0]    w_w1c;
  logic [NCH-1:0]    w_expire;
  logic              w_unused;

  // A new access is only accepted while the previous completion pulse is low,
  // which makes back-to-back transfers complete every second cycle.
  assign w_access     = s_apb.psel & s_apb.penable & ~r_pready;
  assign w_wr         = w_access & s_apb.pwrite;
  assign w_rd         = w_access & ~s_apb.pwrite;
  assign w_chRegion   = (s_apb.paddr[15:8] == 8'h00);
  assign w_chIdx      = s_apb.paddr[7:4];
  assign w_regSel     = s_apb.paddr[3:2];
  assign w_isIrqSum   = (s_apb.paddr[15:2] == 14'h0040);
  assign w_isPrescale = (s_apb.paddr[15:2] == 14'h0041);

  // Byte-lane bits and data bits beyond the implemented fields are ignored.
  assign w_unused = &{1'b0, s_apb.paddr[1:0], s_apb.pwdata};

`ifdef APB_TIMER_MULTI_PRESCALE_EN
  logic [15:0] r_prescale;
  logic [15:0] r_psCnt;
  logic        w_wrPrescale;

  assign w_wrPrescale = w_wr & w_isPrescale;
  assign w_tick       = (r_psCnt == r_prescale);

  // Shared prescaler: counts 0..PRESCALE, ticks and wraps; a PRESCALE write restarts it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prescale <= '0;
      r_psCnt    <= '0;
    end else if (w_wrPrescale) begin
      r_prescale <= s_apb.pwdata[15:0];
      r_psCnt    <= '0;
    end else if (w_tick) begin
      r_psCnt    <= '0;
    end else begin
      r_psCnt    <= r_psCnt + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Per-channel write strobes decoded from the accepted bus write.
  always_comb begin
    w_wrCtrl = '0;
    w_wrLoad = '0;
    w_w1c    = '0;
    for (int n = 0; n < NCH; n++) begin
      if (w_wr && w_chRegion && (w_chIdx == 4'(n))) begin
        w_wrCtrl[n] = (w_regSel == 2'd0);
        w_wrLoad[n] = (w_regSel == 2'd1);
        w_w1c[n]    = (w_regSel == 2'd3) & s_apb.pwdata[0];
      end
    end
  end

  // A channel expires on a tick while enabled at zero; a same-cycle LOAD write pre-empts the tick.
  always_comb begin
    w_expire = '0;
    for (int n = 0; n < NCH; n++) begin
      w_expire[n] = w_tick & r_en[n] & ~w_wrLoad[n] & (r_count[n] == '0);
    end
  end

  // Channel state: LOAD write beats the tick, CTRL write beats the one-shot EN clear,
  // and an expiry beats a simultaneous W1C of PEND.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en       <= '0;
      r_periodic <= '0;
      r_ie       <= '0;
      r_pend     <= '0;
      for (int n = 0; n < NCH; n++) begin
        r_load[n]  <= '0;
        r_count[n] <= '0;
      end
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (w_wrLoad[n]) begin
          r_load[n]  <= s_apb.pwdata[CWIDTH-1:0];
          r_count[n] <= s_apb.pwdata[CWIDTH-1:0];
        end else if (w_tick && r_en[n]) begin
          if (r_count[n] != '0) begin
            r_count[n] <= r_count[n] - 1'b1;
          end else if (r_periodic[n]) begin
            r_count[n] <= r_load[n];
          end
        end

        if (w_wrCtrl[n]) begin
          r_en[n]       <= s_apb.pwdata[0];
          r_periodic[n] <= s_apb.pwdata[1];
          r_ie[n]       <= s_apb.pwdata[2];
        end else if (w_expire[n] && !r_periodic[n]) begin
          r_en[n]       <= 1'b0;
        end

        if (w_expire[n]) begin
          r_pend[n] <= 1'b1;
        end else if (w_w1c[n]) begin
          r_pend[n] <= 1'b0;
        end
      end
    end
  end

  assign w_irq  = r_pend & r_ie;
  assign o_irq  = w_irq;
  assign o_done = |w_irq;

  // Read multiplexer: unmapped addresses and channels at or above NCH read 0.
  always_comb begin
    w_rdata = '0;
    if (w_chRegion) begin
      for (int n = 0; n < NCH; n++) begin
        if (w_chIdx == 4'(n)) begin
          case (w_regSel)
            2'd0:    w_rdata[2:0]        = {r_ie[n], r_periodic[n], r_en[n]};
            2'd1:    w_rdata[CWIDTH-1:0] = r_load[n];
            2'd2:    w_rdata[CWIDTH-1:0] = r_count[n];
            default: w_rdata[0]          = r_pend[n];
          endcase
        end
      end
    end else if (w_isIrqSum) begin
      w_rdata[NCH-1:0] = w_irq;
    end else if (w_isPrescale) begin
`ifdef APB_TIMER_MULTI_PRESCALE_EN
      w_rdata[15:0] = r_prescale;
`else
      w_rdata = '0;
`endif
    end
  end

  // Completion pulse and registered read data; data is forced to 0 outside the pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pready <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_pready <= w_access;
      r_prdata <= w_rd ? w_rdata : 32'h0;
    end
  end

  assign s_apb.pready = r_pready;
  assign s_apb.prdata = r_prdata;

endmodule

// File: tb/tb_apb_timer_multi.sv
// Testbench for apb_timer_multi: a default 4x32 instance (A) and a 2x8 instance (B).
// Read expectations are queued when a transfer is issued and checked by a
// negedge monitor whenever a DUT raises PREADY.
module tb_apb_timer_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] irqA;
  logic       doneA;
  logic [1:0] irqB;
  logic       doneB;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    int          dut;
    bit          chk;
    logic [31:0] expData;
    string       name;
  } expEntry_t;

  expEntry_t expQ[$];
  bit prevA = 1'b0;
  bit prevB = 1'b0;

  apb_timer_multi_if busA ();
  apb_timer_multi_if busB ();

  apb_timer_multi #(.NCH(4), .CWIDTH(32)) dutA (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_apb   (busA.slave),
    .o_irq   (irqA),
    .o_done  (doneA)
  );

  apb_timer_multi #(.NCH(2), .CWIDTH(8)) dutB (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .s_apb   (busB.slave),
    .o_irq   (irqB),
    .o_done  (doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nTests++;
    if (act !== expv) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic checkResp(input int dut, input logic [31:0] data);
    expEntry_t e;
    if (expQ.size() == 0) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL unexpected PREADY on DUT %0d: got data 0x%0h, expected no response", dut, data);
    end else begin
      e = expQ.pop_front();
      if (e.dut != dut) begin
        nTests++;
        nFail++;
        $display("[TB] FAIL %s: response from DUT %0d, expected DUT %0d", e.name, dut, e.dut);
      end else if (e.chk) begin
        checkOutput(e.name, data, e.expData);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every completion and checks the pulse is one cycle wide.
  always @(negedge clk) begin
    if (prevA) checkOutput("PREADY width A", {31'h0, busA.pready}, 32'h0);
    if (prevB) checkOutput("PREADY width B", {31'h0, busB.pready}, 32'h0);
    prevA = busA.pready;
    prevB = busB.pready;
    if (busA.pready) checkResp(0, busA.prdata);
    if (busB.pready) checkResp(1, busB.prdata);
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int dut, input bit wr, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input bit chk, input string name);
    expEntry_t e;
    bit gotReady;
    int waited;
    e.dut = dut; e.chk = chk; e.expData = expData; e.name = name;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (dut == 0) begin
      busA.psel = 1'b1; busA.penable = 1'b1; busA.pwrite = wr; busA.paddr = addr; busA.pwdata = wdata;
    end else begin
      busB.psel = 1'b1; busB.penable = 1'b1; busB.pwrite = wr; busB.paddr = addr; busB.pwdata = wdata;
    end
    gotReady = 1'b0;
    waited = 0;
    while (!gotReady && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
      gotReady = (dut == 0) ? busA.pready : busB.pready;
    end
    busA.psel = 1'b0; busA.penable = 1'b0;
    busB.psel = 1'b0; busB.penable = 1'b0;
    if (!gotReady) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL %s: PREADY got 0 for 8 cycles, expected 1", name);
      void'(expQ.pop_back());
    end
  endtask

  task automatic wrA(input logic [15:0] a, input logic [31:0] d, input string n);
    applyStimulus(0, 1'b1, a, d, 32'h0, 1'b0, n);
  endtask
  task automatic rdA(input logic [15:0] a, input logic [31:0] x, input string n);
    applyStimulus(0, 1'b0, a, 32'h0, x, 1'b1, n);
  endtask
  task automatic wrB(input logic [15:0] a, input logic [31:0] d, input string n);
    applyStimulus(1, 1'b1, a, d, 32'h0, 1'b0, n);
  endtask
  task automatic rdB(input logic [15:0] a, input logic [31:0] x, input string n);
    applyStimulus(1, 1'b0, a, 32'h0, x, 1'b1, n);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    busA.psel = 1'b0; busA.penable = 1'b0; busA.pwrite = 1'b0; busA.paddr = '0; busA.pwdata = '0;
    busB.psel = 1'b0; busB.penable = 1'b0; busB.pwrite = 1'b0; busB.paddr = '0; busB.pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset PREADY", {31'h0, busA.pready}, 32'h0);
    checkOutput("reset PRDATA", busA.prdata, 32'h0);
    checkOutput("reset IRQ", {28'h0, irqA}, 32'h0);
    checkOutput("reset DONE", {31'h0, doneA}, 32'h0);
    rst_n = 1'b1;

    // Every register reads 0 after reset.
    for (int ch = 0; ch < 4; ch++) begin
      for (int r = 0; r < 4; r++) begin
        rdA(16'(ch * 16 + r * 4), 32'h0, $sformatf("reset ch%0d reg%0d", ch, r));
      end
    end
    rdA(16'h0100, 32'h0, "reset IRQSUM");
    rdA(16'h0104, 32'h0, "reset PRESCALE");
    checkOutput("reset DONE after reads", {31'h0, doneA}, 32'h0);

    // Ch0 one-shot countdown from 5 with IE.
    wrA(16'h0004, 32'd5, "ch0 LOAD");
    wrA(16'h0000, 32'h5, "ch0 CTRL");
    rdA(16'h0008, 32'd4, "ch0 COUNT 4");
    rdA(16'h0008, 32'd2, "ch0 COUNT 2");
    waitCycles(1);
    checkOutput("ch0 IRQ before expiry", {28'h0, irqA}, 32'h0);
    checkOutput("ch0 DONE before expiry", {31'h0, doneA}, 32'h0);
    waitCycles(1);
    checkOutput("ch0 IRQ after expiry", {28'h0, irqA}, 32'h1);
    checkOutput("ch0 DONE after expiry", {31'h0, doneA}, 32'h1);
    rdA(16'h0000, 32'h4, "ch0 CTRL EN cleared");
    rdA(16'h0008, 32'h0, "ch0 COUNT holds 0");
    rdA(16'h000C, 32'h1, "ch0 STATUS pend");
    wrA(16'h000C, 32'h1, "ch0 W1C");
    checkOutput("ch0 IRQ after W1C", {28'h0, irqA}, 32'h0);
    rdA(16'h000C, 32'h0, "ch0 STATUS cleared");

    // Ch2 periodic LOAD=3 without IE, then IE, then W1C.
    wrA(16'h0024, 32'd3, "ch2 LOAD");
    wrA(16'h0020, 32'h3, "ch2 CTRL periodic");
    rdA(16'h002C, 32'h0, "ch2 STATUS before expiry");
    rdA(16'h0028, 32'h0, "ch2 COUNT at 0");
    rdA(16'h002C, 32'h1, "ch2 STATUS pend");
    checkOutput("ch2 IRQ masked", {28'h0, irqA}, 32'h0);
    checkOutput("ch2 DONE masked", {31'h0, doneA}, 32'h0);
    rdA(16'h0028, 32'h0, "ch2 COUNT second period 0");
    rdA(16'h0028, 32'd2, "ch2 COUNT reloaded 2");
    wrA(16'h0020, 32'h7, "ch2 CTRL IE");
    checkOutput("ch2 IRQ enabled", {28'h0, irqA}, 32'h4);
    checkOutput("ch2 DONE enabled", {31'h0, doneA}, 32'h1);
    rdA(16'h0100, 32'h4, "IRQSUM ch2");
    waitCycles(1);
    wrA(16'h002C, 32'h1, "ch2 W1C");
    checkOutput("ch2 IRQ after W1C", {28'h0, irqA}, 32'h0);
    wrA(16'h0020, 32'h0, "ch2 CTRL off");
    rdA(16'h002C, 32'h0, "ch2 STATUS after stop");

    // Ch1 periodic LOAD=0: expiry every tick, so W1C never wins.
    wrA(16'h0014, 32'h0, "ch1 LOAD 0");
    wrA(16'h0010, 32'h7, "ch1 CTRL periodic IE");
    for (int i = 0; i < 3; i++) begin
      wrA(16'h001C, 32'h1, "ch1 W1C");
      checkOutput($sformatf("ch1 set wins %0d", i), {28'h0, irqA}, 32'h2);
    end
    rdA(16'h001C, 32'h1, "ch1 STATUS set wins");
    wrA(16'h0010, 32'h0, "ch1 CTRL off");
    checkOutput("ch1 IRQ IE off", {28'h0, irqA}, 32'h0);
    wrA(16'h001C, 32'h1, "ch1 W1C final");
    rdA(16'h001C, 32'h0, "ch1 STATUS cleared");
    checkOutput("DONE idle", {31'h0, doneA}, 32'h0);

`ifdef APB_TIMER_MULTI_PRESCALE_EN
    // PRESCALE=2: tick every 3 cycles, ch0 LOAD=1 periodic expires every 6 cycles.
    wrA(16'h0104, 32'd2, "PRESCALE write");
    rdA(16'h0104, 32'd2, "PRESCALE readback");
    wrA(16'h0004, 32'd1, "ch0 LOAD 1");
    wrA(16'h0000, 32'h7, "ch0 CTRL periodic IE");
    waitCycles(5);
    checkOutput("prescale no expiry yet", {28'h0, irqA}, 32'h0);
    waitCycles(1);
    checkOutput("prescale first expiry", {28'h0, irqA}, 32'h1);
    wrA(16'h000C, 32'h1, "ch0 W1C prescale");
    checkOutput("prescale cleared", {28'h0, irqA}, 32'h0);
    waitCycles(3);
    checkOutput("prescale between expiries", {28'h0, irqA}, 32'h0);
    waitCycles(1);
    checkOutput("prescale second expiry", {28'h0, irqA}, 32'h1);
`else
    // No prescaler: 0x104 ignores writes, ch0 LOAD=1 periodic expires every 2 cycles.
    wrA(16'h0104, 32'hFFFF, "PRESCALE write");
    rdA(16'h0104, 32'h0, "PRESCALE reads 0");
    wrA(16'h0004, 32'd1, "ch0 LOAD 1");
    wrA(16'h0000, 32'h7, "ch0 CTRL periodic IE");
    waitCycles(1);
    checkOutput("period2 no expiry yet", {28'h0, irqA}, 32'h0);
    waitCycles(1);
    checkOutput("period2 first expiry", {28'h0, irqA}, 32'h1);
    waitCycles(1);
    wrA(16'h000C, 32'h1, "ch0 W1C period2");
    checkOutput("period2 cleared", {28'h0, irqA}, 32'h0);
    waitCycles(1);
    checkOutput("period2 next expiry", {28'h0, irqA}, 32'h1);
`endif
    wrA(16'h0000, 32'h0, "ch0 CTRL off");
    wrA(16'h000C, 32'h1, "ch0 W1C cleanup");
    checkOutput("ch0 IRQ cleanup", {28'h0, irqA}, 32'h0);

    // Unmapped addresses on A.
    rdA(16'h0200, 32'h0, "unmapped 0x200");
    rdA(16'h0080, 32'h0, "channel 8 region");

    // Narrow instance B: NCH=2, CWIDTH=8.
    wrB(16'h0014, 32'h1FF, "B ch1 LOAD wide");
    rdB(16'h0014, 32'hFF, "B ch1 LOAD truncated");
    rdB(16'h0018, 32'hFF, "B ch1 COUNT truncated");
    rdB(16'h0020, 32'h0, "B ch2 CTRL absent");
    wrB(16'h0024, 32'h5, "B ch2 LOAD absent");
    rdB(16'h0024, 32'h0, "B ch2 LOAD ignored");
    checkOutput("B DONE idle", {31'h0, doneB}, 32'h0);

    // Reset while PREADY is high drops it immediately.
    wrA(16'h0034, 32'h77, "ch3 LOAD");
    rdA(16'h0034, 32'h77, "ch3 LOAD readback");
    @(posedge clk);
    #1;
    busA.psel = 1'b1; busA.penable = 1'b1; busA.pwrite = 1'b0; busA.paddr = 16'h0034;
    @(posedge clk);
    #1;
    checkOutput("PREADY before reset", {31'h0, busA.pready}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("PREADY dropped by reset", {31'h0, busA.pready}, 32'h0);
    checkOutput("PRDATA dropped by reset", busA.prdata, 32'h0);
    busA.psel = 1'b0; busA.penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdA(16'h0034, 32'h0, "ch3 LOAD after reset");

    waitCycles(3);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
